// File: rtl/kara_pkg.sv
// Shared constants and state encoding for the Karatsuba multiplier product
// accumulator stage.
package kara_pkg;

   localparam int MUL_N = 32;
   localparam int PW    = 2 * MUL_N;
   localparam int GW    = 16;
   localparam int AW    = PW + GW;
   localparam int LW    = 8;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ACC  = 2'd1,
      HOLD = 2'd2
   } state_t;

endpackage

// File: rtl/kara_prod_accum_if.sv
// Product input and result output handshakes of the product accumulator.
interface kara_prod_accum_if #(
   parameter int PW = kara_pkg::PW,
   parameter int AW = kara_pkg::AW,
   parameter int LW = kara_pkg::LW
);

   logic          in_valid;
   logic          in_ready;
   logic [PW-1:0] in_prod;
   logic          out_valid;
   logic          out_ready;
   logic [AW-1:0] out_sum;
   logic [LW-1:0] out_cnt;
   logic          out_ovf;

   modport master (
      output in_valid, in_prod, out_ready,
      input  in_ready, out_valid, out_sum, out_cnt, out_ovf
   );

   modport slave (
      input  in_valid, in_prod, out_ready,
      output in_ready, out_valid, out_sum, out_cnt, out_ovf
   );

endinterface

// File: rtl/kara_prod_accum.sv
// Accumulates a programmed number of 64-bit multiplier products into a
// guarded sum and presents the result over a valid/ready port.
module kara_prod_accum #(
   parameter int PW = kara_pkg::PW,
   parameter int GW = kara_pkg::GW,
   parameter int LW = kara_pkg::LW
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          start,
   input  logic [LW-1:0] len,
   input  logic          abort,
   output logic          busy,
   kara_prod_accum_if.slave bus
);

   import kara_pkg::*;

   localparam int AW = PW + GW;

   state_t        state, state_n;
   logic [AW-1:0] acc;
   logic [LW-1:0] cnt;
   logic [LW-1:0] len_q;
   logic          ovf;
   logic          xfer;
   logic [AW:0]   sum_w;

   assign sum_w = {1'b0, acc} + (AW+1)'(bus.in_prod);

   always_ff @(posedge clk) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_n;
   end

   // abort outranks a coincident transfer, so xfer is masked here
   always_comb begin
      state_n = state;
      xfer    = 1'b0;
      case (state)
         IDLE: begin
            if (start) state_n = (len == '0) ? HOLD : ACC;
         end
         ACC: begin
            xfer = bus.in_valid & ~abort;
            if (abort)
               state_n = IDLE;
            else if (bus.in_valid && ((cnt + LW'(1)) == len_q))
               state_n = HOLD;
         end
         HOLD: begin
            if (abort || bus.out_ready) state_n = IDLE;
         end
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         acc   <= '0;
         cnt   <= '0;
         len_q <= '0;
         ovf   <= 1'b0;
      end else if (state == IDLE && start) begin
         acc   <= '0;
         cnt   <= '0;
         len_q <= len;
         ovf   <= 1'b0;
      end else if (xfer) begin
         acc <= sum_w[AW-1:0];
         cnt <= cnt + LW'(1);
         if (sum_w[AW]) ovf <= 1'b1;
      end
   end

   assign bus.in_ready  = (state == ACC);
   assign bus.out_valid = (state == HOLD);
   assign bus.out_sum   = acc;
   assign bus.out_cnt   = cnt;
   assign bus.out_ovf   = ovf;
   assign busy          = (state != IDLE);

   a_valid_in_hold: assert property (@(posedge clk) disable iff (!rst_n)
      bus.out_valid |-> (state == HOLD));

   a_out_stable: assert property (@(posedge clk) disable iff (!rst_n)
      (bus.out_valid && !bus.out_ready && !abort) |=>
         (bus.out_valid && $stable(bus.out_sum) && $stable(bus.out_cnt) && $stable(bus.out_ovf)));

   a_cnt_bound: assert property (@(posedge clk) disable iff (!rst_n)
      cnt <= len_q);

endmodule

// File: tb/tb_kara_prod_accum.sv
// Randomized and directed checks of kara_prod_accum against a plain
// arithmetic model of the accumulated run.
module tb_kara_prod_accum;

   logic clk = 1'b0;
   logic rst_n;
   logic start, abort, busy;
   logic [7:0] len;
   logic start1, abort1, busy1;
   logic [7:0] len1;

   int unsigned checks = 0;
   int unsigned errors = 0;

   kara_prod_accum_if #(.PW(64), .AW(80), .LW(8)) bus ();
   kara_prod_accum_if #(.PW(64), .AW(65), .LW(8)) bus1 ();

   kara_prod_accum #(.PW(64), .GW(16), .LW(8)) u_dut (
      .clk(clk), .rst_n(rst_n), .start(start), .len(len),
      .abort(abort), .busy(busy), .bus(bus)
   );

   kara_prod_accum #(.PW(64), .GW(1), .LW(8)) u_dut1 (
      .clk(clk), .rst_n(rst_n), .start(start1), .len(len1),
      .abort(abort1), .busy(busy1), .bus(bus1)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got %0h expected %0h", tag, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // mode: 0 random, 1 all-ones, 2 ascending 1..n, 3 constant 5
   task automatic do_run(input int unsigned n, input int unsigned mode,
                         input int unsigned gap_pct, input int unsigned bp);
      logic [127:0] full;
      logic [63:0]  p;
      int unsigned  sent, budget;
      bit           was;
      full = '0;
      sent = 0;
      budget = 0;
      check("idle_ready", bus.in_ready, 0);
      start = 1'b1;
      len = n[7:0];
      tick();
      start = 1'b0;
      check("busy", busy, 1);
      if (n == 0) check("len0_ready", bus.in_ready, 0);
      while (sent < n && budget < 5000) begin
         case (mode)
            1:       p = '1;
            2:       p = 64'(sent + 1);
            3:       p = 64'd5;
            default: p = {$urandom, $urandom};
         endcase
         bus.in_prod  = p;
         bus.in_valid = ($urandom_range(99) >= gap_pct);
         was = bus.in_valid;
         check("acc_ready", bus.in_ready, 1);
         tick();
         if (was) begin
            full += 128'(p);
            sent++;
         end
         budget++;
      end
      bus.in_valid = 1'b0;
      if (sent < n) check("run_timeout", 128'(sent), 128'(n));
      check("lat_valid", bus.out_valid, 1);
      check("hold_ready", bus.in_ready, 0);
      check("sum", 128'(bus.out_sum), 128'(full[79:0]));
      check("cnt", 128'(bus.out_cnt), 128'(n[7:0]));
      check("ovf", bus.out_ovf, |full[127:80]);
      for (int unsigned i = 0; i < bp; i++) begin
         bus.out_ready = 1'b0;
         tick();
         check("bp_valid", bus.out_valid, 1);
         check("bp_sum", 128'(bus.out_sum), 128'(full[79:0]));
         check("bp_cnt", 128'(bus.out_cnt), 128'(n[7:0]));
      end
      bus.out_ready = 1'b1;
      tick();
      bus.out_ready = 1'b0;
      check("drop_valid", bus.out_valid, 0);
      check("drop_busy", busy, 0);
   endtask

   initial begin
      rst_n = 1'b0;
      start = 1'b0; abort = 1'b0; len = '0;
      start1 = 1'b0; abort1 = 1'b0; len1 = '0;
      bus.in_valid = 1'b0; bus.in_prod = '0; bus.out_ready = 1'b0;
      bus1.in_valid = 1'b0; bus1.in_prod = '0; bus1.out_ready = 1'b0;
      tick();
      tick();
      rst_n = 1'b1;
      check("rst_valid", bus.out_valid, 0);
      check("rst_ready", bus.in_ready, 0);
      check("rst_busy", busy, 0);

      // reset in the middle of a run
      start = 1'b1; len = 8'd10;
      tick();
      start = 1'b0;
      bus.in_valid = 1'b1; bus.in_prod = 64'd77;
      repeat (3) tick();
      bus.in_valid = 1'b0;
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      check("mid_rst_busy", busy, 0);
      check("mid_rst_ready", bus.in_ready, 0);
      check("mid_rst_valid", bus.out_valid, 0);
      check("mid_rst_sum", 128'(bus.out_sum), 0);
      check("mid_rst_cnt", 128'(bus.out_cnt), 0);
      check("mid_rst_ovf", bus.out_ovf, 0);
      do_run(1, 3, 0, 0);

      do_run(4, 2, 0, 0);
      do_run(2, 1, 0, 5);
      do_run(0, 0, 0, 2);
      do_run(255, 1, 0, 0);

      // abort with a coincident transfer and start
      start = 1'b1; len = 8'd3;
      tick();
      start = 1'b0;
      bus.in_valid = 1'b1; bus.in_prod = 64'd9;
      tick();
      abort = 1'b1; start = 1'b1; len = 8'd1;
      tick();
      abort = 1'b0; start = 1'b0; bus.in_valid = 1'b0;
      check("abort_valid", bus.out_valid, 0);
      check("abort_busy", busy, 0);
      for (int i = 0; i < 3; i++) begin
         tick();
         check("post_abort_valid", bus.out_valid, 0);
         check("post_abort_busy", busy, 0);
      end

      // start together with abort in IDLE is honoured
      start = 1'b1; abort = 1'b1; len = 8'd2;
      tick();
      start = 1'b0; abort = 1'b0;
      check("idle_abort_start", bus.in_ready, 1);
      abort = 1'b1;
      tick();
      abort = 1'b0;
      check("acc_abort_busy", busy, 0);

      // abort while holding a result
      start = 1'b1; len = 8'd0;
      tick();
      start = 1'b0;
      check("hold_before_abort", bus.out_valid, 1);
      abort = 1'b1;
      tick();
      abort = 1'b0;
      check("hold_abort_valid", bus.out_valid, 0);

      // narrow guard: three all-ones products carry out of 65 bits
      start1 = 1'b1; len1 = 8'd3;
      tick();
      start1 = 1'b0;
      bus1.in_valid = 1'b1; bus1.in_prod = '1;
      repeat (3) tick();
      bus1.in_valid = 1'b0;
      check("g1_valid", bus1.out_valid, 1);
      check("g1_sum", 128'(bus1.out_sum), 128'h0_FFFF_FFFF_FFFF_FFFD);
      check("g1_cnt", 128'(bus1.out_cnt), 3);
      check("g1_ovf", bus1.out_ovf, 1);
      bus1.out_ready = 1'b1;
      tick();
      bus1.out_ready = 1'b0;
      check("g1_busy", busy1, 0);

      for (int r = 0; r < 20; r++)
         do_run($urandom_range(0, 12), 0, 30, $urandom_range(0, 3));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
